// File: rtl/lms_coeff_update_if.sv
// Sample/control inputs and coefficient/status outputs of the LMS adaptation stage.
// The FIR-side driver uses the master modport; lms_coeff_update uses slave.
interface lms_coeff_update_if #(
    parameter int FILT_LENGTH = 16
);
    logic                          en;
    logic signed [15:0]            din;
    logic signed [15:0]            y;
    logic signed [15:0]            d;
    logic                          adapt;
    logic [16*(FILT_LENGTH/2)-1:0] coeff_flat;
    logic signed [15:0]            err;
    logic                          busy;
    logic                          done;
    logic                          overrun;

    modport master (
        output en, din, y, d, adapt,
        input  coeff_flat, err, busy, done, overrun
    );

    modport slave (
        input  en, din, y, d, adapt,
        output coeff_flat, err, busy, done, overrun
    );
endinterface

// File: rtl/lms_coeff_update.sv
// LMS coefficient adaptation for the folded symmetric FIR: captures the error on en,
// then updates one folded coefficient per clock while driving the packed coefficient bus.
module lms_coeff_update #(
    parameter int                            FILT_LENGTH = 16,
    parameter int                            MU_SHIFT    = 4,
    parameter logic [16*(FILT_LENGTH/2)-1:0] COEFF_INIT  = {16'd13200, 16'd12396, 16'd11427, 16'd9265,
                                                            16'd8006,  16'd5051,  16'd4557,  16'd2552}
) (
    input  logic              clk,
    input  logic              rst_n,
    lms_coeff_update_if.slave bus
);
    localparam int NCOEF = FILT_LENGTH / 2;
    localparam int KW    = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int SHIFT = 15 + MU_SHIFT;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             r_state;
    logic [KW-1:0]      r_k;
    logic signed [15:0] r_x     [FILT_LENGTH];
    logic signed [16:0] r_fold  [NCOEF];
    logic signed [15:0] r_coeff [NCOEF];
    logic signed [15:0] r_err;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;

    logic signed [16:0]  w_diff;
    logic signed [32:0]  w_prod;
    logic signed [32:0]  w_delta;
    logic signed [33:0]  w_sum;
    logic [16*NCOEF-1:0] w_coeffFlat;

    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -34'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    // Wide intermediates so neither the error nor the coefficient sum can wrap before clamping.
    assign w_diff  = 17'(bus.d) - 17'(bus.y);
    assign w_prod  = 33'(r_fold[r_k]) * 33'(r_err);
    assign w_delta = w_prod >>> SHIFT;
    assign w_sum   = 34'(r_coeff[r_k]) + 34'(w_delta);

    // The delay line tracks the FIR on every en, even while a pass is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FILT_LENGTH; i++) begin
                r_x[i] <= '0;
            end
        end else if (bus.en) begin
            r_x[0] <= bus.din;
            for (int i = 1; i < FILT_LENGTH; i++) begin
                r_x[i] <= r_x[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                r_fold[i]  <= '0;
                r_coeff[i] <= COEFF_INIT[16*i +: 16];
            end
        end else begin
            r_done <= 1'b0;
            if (bus.en && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (bus.en) begin
                        r_err <= sat16(34'(w_diff));
                        // Fold from the pre-shift taps: these are the samples that produced y.
                        for (int i = 0; i < NCOEF; i++) begin
                            r_fold[i] <= 17'(r_x[i]) + 17'(r_x[FILT_LENGTH-1-i]);
                        end
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (bus.adapt) begin
                        r_coeff[r_k] <= sat16(w_sum);
                    end
                    if (r_k == KW'(NCOEF - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_coeffFlat = '0;
        for (int i = 0; i < NCOEF; i++) begin
            w_coeffFlat[16*i +: 16] = r_coeff[i];
        end
    end

    assign bus.coeff_flat = w_coeffFlat;
    assign bus.err        = r_err;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_lms_coeff_update.sv
// Scoreboard bench for lms_coeff_update: directed samples drive two instances (default and near-rail
// coefficients); each accepted sample pushes its expected err/coefficients, popped on done.
module tb_lms_coeff_update;
    localparam logic [127:0] INIT_A = {16'd13200, 16'd12396, 16'd11427, 16'd9265,
                                       16'd8006,  16'd5051,  16'd4557,  16'd2552};
    localparam logic [127:0] INIT_B = {16'd13200, 16'd12396, 16'd11427, 16'h8044,
                                       16'h7FBC,  16'd5051,  16'd4557,  16'd2552};

    typedef struct {
        logic [15:0]  err;
        logic [127:0] cA;
        logic [127:0] cB;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lms_coeff_update_if #(.FILT_LENGTH(16)) ifA ();
    lms_coeff_update_if #(.FILT_LENGTH(16)) ifB ();

    assign ifB.en    = ifA.en;
    assign ifB.din   = ifA.din;
    assign ifB.y     = ifA.y;
    assign ifB.d     = ifA.d;
    assign ifB.adapt = ifA.adapt;

    lms_coeff_update #(.FILT_LENGTH(16), .MU_SHIFT(4), .COEFF_INIT(INIT_A)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    lms_coeff_update #(.FILT_LENGTH(16), .MU_SHIFT(4), .COEFF_INIT(INIT_B)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    exp_t               sbQ[$];
    int                 testsRun    = 0;
    int                 testsFailed = 0;
    int                 acceptCount = 0;
    int                 doneCount   = 0;
    logic signed [15:0] mX  [16];
    int                 mCA [8];
    int                 mCB [8];

    function automatic int satVal(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic logic [127:0] packCoeffs(input int c [8]);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p[16*i +: 16] = 16'(c[i]);
        end
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        logic [127:0] ia;
        logic [127:0] ib;
        ia = INIT_A;
        ib = INIT_B;
        for (int i = 0; i < 16; i++) begin
            mX[i] = '0;
        end
        for (int i = 0; i < 8; i++) begin
            mCA[i] = int'($signed(ia[16*i +: 16]));
            mCB[i] = int'($signed(ib[16*i +: 16]));
        end
    endtask

    // One en pulse; when acceptance is expected the model computes the whole pass up front.
    task automatic applyStimulus(input logic [15:0] dinV, input logic [15:0] yV, input logic [15:0] dV,
                                 input logic adaptV, input logic expectAccept);
        longint fold;
        longint e;
        exp_t   ex;
        @(negedge clk);
        ifA.en    = 1'b1;
        ifA.din   = dinV;
        ifA.y     = yV;
        ifA.d     = dV;
        ifA.adapt = adaptV;
        if (expectAccept) begin
            e = longint'(satVal(longint'($signed(dV)) - longint'($signed(yV))));
            for (int k = 0; k < 8; k++) begin
                fold = longint'(mX[k]) + longint'(mX[15-k]);
                if (adaptV) begin
                    mCA[k] = satVal(longint'(mCA[k]) + ((fold * e) >>> 19));
                    mCB[k] = satVal(longint'(mCB[k]) + ((fold * e) >>> 19));
                end
            end
            ex.err = 16'(e);
            ex.cA  = packCoeffs(mCA);
            ex.cB  = packCoeffs(mCB);
            sbQ.push_back(ex);
            acceptCount++;
        end
        for (int i = 15; i > 0; i--) begin
            mX[i] = mX[i-1];
        end
        mX[0] = dinV;
        @(negedge clk);
        ifA.en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && ifA.done) begin
            exp_t ex;
            doneCount++;
            if (sbQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL sb done with empty queue: got done=1, expected none");
            end else begin
                ex = sbQ.pop_front();
                checkOutput("sb err", ifA.err[15:0], ex.err);
                checkOutput("sb coeffA", ifA.coeff_flat, ex.cA);
                checkOutput("sb coeffB", ifB.coeff_flat, ex.cB);
                checkOutput("sb doneB", ifB.done, 1);
            end
        end
    end

    initial begin
        int busyCycles;
        int doneCycle;
        int doneBefore;

        ifA.en    = 1'b0;
        ifA.din   = '0;
        ifA.y     = '0;
        ifA.d     = '0;
        ifA.adapt = 1'b0;
        modelReset();

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset coeffA", ifA.coeff_flat, INIT_A);
        checkOutput("reset coeffB", ifB.coeff_flat, INIT_B);
        checkOutput("reset err", ifA.err[15:0], 0);
        checkOutput("reset busy", ifA.busy, 0);
        checkOutput("reset done", ifA.done, 0);
        checkOutput("reset overrun", ifA.overrun, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
        checkOutput("err sat pos", ifA.err[15:0], 16'h7FFF);
        idle(11);
        applyStimulus(16'h0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
        checkOutput("err sat neg", ifA.err[15:0], 16'h8000);
        idle(11);
        applyStimulus(16'h0000, 16'd40, 16'd100, 1'b0, 1'b1);
        checkOutput("err plain", ifA.err[15:0], 16'd60);
        idle(11);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(16'h1000, 16'h0000, 16'h0000, 1'b0, 1'b1);
            idle(11);
        end

        applyStimulus(16'h1000, 16'h0000, 16'h2000, 1'b1, 1'b1);
        busyCycles = 0;
        doneCycle  = -1;
        for (int c = 1; c <= 12; c++) begin
            if (ifA.busy) busyCycles++;
            if (ifA.done && (doneCycle < 0)) doneCycle = c;
            @(negedge clk);
        end
        checkOutput("nominal busy cycles", busyCycles, 9);
        checkOutput("nominal done cycle", doneCycle, 9);
        checkOutput("nominal c0", ifA.coeff_flat[15:0], 16'd2680);
        checkOutput("nominal c7", ifA.coeff_flat[127:112], 16'd13328);
        checkOutput("sat B c3 high", ifB.coeff_flat[63:48], 16'h7FFF);
        checkOutput("B c4 after +128", ifB.coeff_flat[79:64], 16'h80C4);

        applyStimulus(16'h1000, 16'h2000, 16'h0000, 1'b1, 1'b1);
        idle(11);
        applyStimulus(16'h1000, 16'h2000, 16'h0000, 1'b1, 1'b1);
        idle(11);
        checkOutput("sat B c4 low", ifB.coeff_flat[79:64], 16'h8000);
        checkOutput("B c3 after -256", ifB.coeff_flat[63:48], 16'd32511);

        applyStimulus(16'h0800, 16'h0000, 16'h2000, 1'b1, 1'b1);
        idle(2);
        applyStimulus(16'h0400, 16'd5, 16'd7, 1'b1, 1'b0);
        checkOutput("overrun err held", ifA.err[15:0], 16'h2000);
        checkOutput("overrun flag", ifA.overrun, 1);
        idle(8);
        checkOutput("overrun sticky", ifA.overrun, 1);
        applyStimulus(16'h1000, 16'h0000, 16'h2000, 1'b1, 1'b1);
        idle(11);
        checkOutput("probe c0", ifA.coeff_flat[15:0], 16'd2632);
        checkOutput("probe c1", ifA.coeff_flat[31:16], 16'd4653);

        doneBefore = doneCount;
        applyStimulus(16'h1000, 16'd100, 16'd300, 1'b0, 1'b1);
        checkOutput("freeze err", ifA.err[15:0], 16'd200);
        idle(11);
        checkOutput("freeze done pulse", doneCount, doneBefore + 1);

        applyStimulus(16'h1000, 16'h0000, 16'h2000, 1'b1, 1'b1);
        idle(3);
        rst_n = 1'b0;
        acceptCount = acceptCount - sbQ.size();
        sbQ.delete();
        modelReset();
        #1;
        checkOutput("midpass reset coeffA", ifA.coeff_flat, INIT_A);
        checkOutput("midpass reset coeffB", ifB.coeff_flat, INIT_B);
        checkOutput("midpass reset busy", ifA.busy, 0);
        checkOutput("midpass reset err", ifA.err[15:0], 0);
        checkOutput("midpass reset overrun", ifA.overrun, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'h1000, 16'h0000, 16'h2000, 1'b1, 1'b1);
        checkOutput("post reset accept", ifA.busy, 1);
        idle(11);

        checkOutput("done count", doneCount, acceptCount);
        checkOutput("queue drained", sbQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/lms_coeff_update.md
Name: lms_coeff_update

Overview:
- LMS adaptation stage, directly downstream of the 16-tap symmetric FIR.
- Consumes the filter input sample, the filter output and a desired signal. Computes the error and adapts the 8 folded coefficients serially, one tap per clock.
- Drives the packed coefficient bus that replaces the FIR's fixed coefficient table.
- Keeps its own 16-deep sample delay line, shifted on the same en strobe as the FIR, so both stay aligned.

Parameters:
- FILT_LENGTH, 16, number of taps; must be even; FILT_LENGTH/2 coefficients are adapted.
- MU_SHIFT, 4, step size mu = 2^-MU_SHIFT; extra right shift applied to each update term.
- COEFF_INIT, {13200,12396,11427,9265,8006,5051,4557,2552}, reset value of coeff[7]..coeff[0], 16 bits each.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample strobe, same signal that advances the FIR delay line.
- din  in  16  signed input sample, same value fed to the FIR.
- y  in  16  signed FIR output (dout), sampled on en.
- d  in  16  signed desired response, sampled on en.
- adapt  in  1  1 = apply coefficient updates; 0 = coefficients frozen, error still computed.
- coeff_flat  out  16*FILT_LENGTH/2  packed signed coefficients; coeff[k] at bits [16k+15:16k].
- err  out  16  signed, saturated error of last accepted sample.
- busy  out  1  high while update FSM is not IDLE.
- done  out  1  one-cycle pulse when an update pass completes.
- overrun  out  1  sticky; set when en arrives while busy; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - coeff[k]=COEFF_INIT[k], delay line all 0, err=0.
  - busy=0, done=0, overrun=0, FSM=IDLE, k=0.
- Delay line:
  - On every clk edge with en=1, regardless of FSM state: x[0]<=din, x[i]<=x[i-1].
- Accept (en=1 and FSM=IDLE):
  - err<=sat16(d-y), computed at 17 bits and clamped to [-32768, 32767].
  - Snapshot fold[k]=x[k]+x[FILT_LENGTH-1-k] at 17 bits signed, using pre-shift delay-line values, i.e. the samples that produced y.
  - FSM->CALC, k<=0.
- CALC, one tap per cycle:
  - prod = fold[k]*err, 33 bits signed.
  - delta = prod >>> (15+MU_SHIFT), arithmetic shift.
  - If adapt=1: coeff[k]<=sat16(coeff[k]+delta); else hold.
  - k++. After k=FILT_LENGTH/2-1, FSM->DONE.
  - adapt is sampled per cycle.
- DONE: done=1 for exactly one cycle, then FSM->IDLE.
- Latency:
  - en edge at cycle 0 -> err valid cycle 1.
  - coeff[k] updated at edge k+1.
  - done high in cycle FILT_LENGTH/2+1 (9 by default).
  - busy high cycles 1..9.
  - Next en accepted at cycle 10 or later; minimum en spacing for full adaptation is 10 clocks.
- en while busy:
  - Delay line still shifts.
  - err, snapshot and FSM unaffected; that sample is not adapted.
  - overrun<=1.
- en in the DONE cycle counts as busy: no accept, overrun set.
- Coefficient outputs are registered. Partially updated coefficients are visible during CALC; the consumer latches coeff_flat on done if coherence is required.
- Saturation: coefficient and err clamp at +32767/-32768, never wrap.
- Reset mid-CALC: immediate return to reset values; no partial pass resumes.

Test Plan:
- Reset:
  - rst_n low for 3 cycles mid-run.
  - Expect coeff_flat = COEFF_INIT (coeff[0]=2552, coeff[7]=13200), err=0, busy=0, overrun=0; asserted asynchronously, without waiting for a clk edge.
- Error saturation:
  - en with d=0x7FFF, y=0x8000 -> err=0x7FFF.
  - d=0x8000, y=0x7FFF -> err=0x8000.
  - d=100, y=40 -> err=60.
- Nominal update:
  - Setup: adapt=0, fill the delay line with 16 en pulses of din=0x1000, spaced 12 cycles.
  - Stimulus: adapt=1, en with d-y=0x2000.
  - Arithmetic: fold=8192, prod=2^26, delta=128.
  - Expect coeff[0]=2680, coeff[7]=13328, done at cycle 9, busy for 9 cycles.
- Coefficient saturation:
  - Setup: COEFF_INIT with coeff[3]=32700; same stimulus as nominal update.
  - Expect coeff[3]=32767.
  - Negative error -0x2000 from coeff=-32700 -> -32768.
- Overrun:
  - en at cycle 0 and again at cycle 4.
  - Expect the pass to complete with first-sample values and overrun=1.
  - Delay line shifted twice: an en-only probe later shows fold from both samples.
  - err unchanged by the second en.
- Freeze and reset mid-pass:
  - adapt=0 through a full pass -> coeff_flat unchanged, err updated, done still pulses.
  - Separately, rst_n low at CALC k=3 -> all coefficients back to COEFF_INIT, FSM IDLE.
